// File: rtl/mark_counter_assembly.sv
// Exhaustive Golomb ruler search: an odometer walks candidate mark sets in lexicographic
// order, one per clock, and keeps the shortest valid rulers seen so far.
module mark_counter_assembly #(
    parameter int MAXVALUE     = 30,
    parameter int NUMPOSITIONS = 5,
    parameter int NUMRESULTS   = 10
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [6:0]                               firstvariableposition,
    input  logic [(NUMPOSITIONS+1)*9-1:0]            firstvalues,
    output logic [(NUMPOSITIONS+1)*9-1:0]            marks,
    output logic [5:0]                               numResults,
    output logic [(NUMPOSITIONS+1)*9*NUMRESULTS-1:0] results,
    output logic                                     done
);
    localparam int N  = NUMPOSITIONS;
    localparam int MW = 9;
    localparam int RW = (N + 1) * MW;
    localparam int IW = $clog2(N + 1);

    typedef logic [MW-1:0] mark_t;

    mark_t         m_q     [0:N];
    mark_t         limit_q;
    logic [5:0]    num_q;
    logic [RW-1:0] res_q   [0:NUMRESULTS-1];
    logic          done_q;

    logic [RW-1:0] cand;
    logic          increasing;
    logic          distinct;
    logic          valid;
    logic          take_new;
    logic          take_tie;
    mark_t         next_limit;
    logic          found;
    logic [IW-1:0] k_sel;
    mark_t         next_m  [0:N];

    // m[0] sits in the most significant slot; result 1 likewise.
    for (genvar i = 0; i <= N; i++) begin : g_marks
        assign cand[(N-i)*MW +: MW] = m_q[i];
    end
    for (genvar r = 0; r < NUMRESULTS; r++) begin : g_results
        assign results[(NUMRESULTS-1-r)*RW +: RW] = res_q[r];
    end

    assign marks      = cand;
    assign numResults = num_q;
    assign done       = done_q;

    // NOTE: every always_comb output gets a default before any conditional write so no latch is inferred.
    always_comb begin
        increasing = 1'b1;
        for (int i = 1; i <= N; i++) begin
            if (m_q[i] <= m_q[i-1]) increasing = 1'b0;
        end

        // Each unordered pair of differences is compared once: (c,d) strictly after (a,b).
        distinct = 1'b1;
        for (int a = 0; a < N; a++) begin
            for (int b = a + 1; b <= N; b++) begin
                for (int c = a; c < N; c++) begin
                    for (int d = c + 1; d <= N; d++) begin
                        if ((c > a || d > b) &&
                            (mark_t'(m_q[b] - m_q[a]) == mark_t'(m_q[d] - m_q[c])))
                            distinct = 1'b0;
                    end
                end
            end
        end

        valid      = increasing && distinct && (m_q[N] <= limit_q);
        take_new   = valid && ((num_q == 6'd0) || (m_q[N] < limit_q));
        take_tie   = valid && !take_new && (m_q[N] == limit_q) &&
                     (num_q < 6'(NUMRESULTS));
        next_limit = take_new ? m_q[N] : limit_q;
    end

    // The odometer digit is chosen against the limit as updated by this cycle's result.
    always_comb begin
        found = 1'b0;
        k_sel = '0;
        for (int k = 0; k <= N; k++) begin
            if ((k >= int'(firstvariableposition)) &&
                (11'(m_q[k]) + 11'(N - k + 1) <= 11'(next_limit))) begin
                found = 1'b1;
                k_sel = IW'(k);
            end
        end

        for (int j = 0; j <= N; j++) begin
            next_m[j] = m_q[j];
            if (found && (j == int'(k_sel)))
                next_m[j] = m_q[j] + mark_t'(1);
            else if (found && (j > int'(k_sel)))
                next_m[j] = m_q[k_sel] + mark_t'(j - int'(k_sel) + 1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the result store is cleared on reset because unused slots must read as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i <= N; i++) m_q[i] <= firstvalues[(N-i)*MW +: MW];
            for (int r = 0; r < NUMRESULTS; r++) res_q[r] <= '0;
            limit_q <= mark_t'(MAXVALUE);
            num_q   <= '0;
            done_q  <= 1'b0;
        end else if (!done_q) begin
            limit_q <= next_limit;
            if (take_new) begin
                for (int r = 0; r < NUMRESULTS; r++) res_q[r] <= (r == 0) ? cand : '0;
                num_q <= 6'd1;
            end else if (take_tie) begin
                for (int r = 0; r < NUMRESULTS; r++) begin
                    if (r == int'(num_q)) res_q[r] <= cand;
                end
                num_q <= num_q + 6'd1;
            end

            if (found) begin
                for (int j = 0; j <= N; j++) m_q[j] <= next_m[j];
            end else begin
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mark_counter_assembly.sv
// Bench for mark_counter_assembly: fixed scenario table, corner sequences, and random
// fixed prefixes checked against a brute-force Golomb enumeration.
module tb_mark_counter_assembly;
    localparam int N    = 5;
    localparam int NR   = 10;
    localparam int MW   = 9;
    localparam int RW   = (N + 1) * MW;
    localparam int RESW = RW * NR;

    typedef struct packed {
        logic [4:0]      maxv;
        logic [6:0]      fvp;
        logic [RW-1:0]   start;
        logic [5:0]      num;
        logic [8*RW-1:0] exp;
        logic [15:0]     cyc;
    } vec_t;

    logic            clock;
    logic            reset;
    logic [6:0]      fvp;
    logic [RW-1:0]   fv;

    logic [RW-1:0]   marks30, marks17, marks16;
    logic [5:0]      num30, num17, num16;
    logic [RESW-1:0] res30, res17, res16;
    logic            done30, done17, done16;

    int              sel;
    logic [RW-1:0]   sel_marks;
    logic [5:0]      sel_num;
    logic [RESW-1:0] sel_results;
    logic            sel_done;

    int total = 0;
    int bad   = 0;

    initial clock = 1'b0;
    always #150 clock = ~clock;

    mark_counter_assembly #(.MAXVALUE(30), .NUMPOSITIONS(N), .NUMRESULTS(NR)) dut30 (
        .clock(clock), .reset(reset), .firstvariableposition(fvp), .firstvalues(fv),
        .marks(marks30), .numResults(num30), .results(res30), .done(done30));
    mark_counter_assembly #(.MAXVALUE(17), .NUMPOSITIONS(N), .NUMRESULTS(NR)) dut17 (
        .clock(clock), .reset(reset), .firstvariableposition(fvp), .firstvalues(fv),
        .marks(marks17), .numResults(num17), .results(res17), .done(done17));
    mark_counter_assembly #(.MAXVALUE(16), .NUMPOSITIONS(N), .NUMRESULTS(NR)) dut16 (
        .clock(clock), .reset(reset), .firstvariableposition(fvp), .firstvalues(fv),
        .marks(marks16), .numResults(num16), .results(res16), .done(done16));

    always_comb begin
        sel_marks = marks30; sel_num = num30; sel_results = res30; sel_done = done30;
        case (sel)
            17: begin sel_marks = marks17; sel_num = num17; sel_results = res17; sel_done = done17; end
            16: begin sel_marks = marks16; sel_num = num16; sel_results = res16; sel_done = done16; end
            default: ;
        endcase
    end

    function automatic logic [RW-1:0] pk(input int a, input int b, input int c,
                                         input int d, input int e, input int f);
        return {9'(a), 9'(b), 9'(c), 9'(d), 9'(e), 9'(f)};
    endfunction

    task automatic check(input string name, input logic [RESW-1:0] act, input logic [RESW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset(input int n);
        @(negedge clock);
        reset = 1'b1;
        repeat (n) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_search(input int budget, output int cycles);
        cycles = 0;
        while (!sel_done && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
        check("done_within_budget", sel_done, 1);
    endtask

    // Reference: enumerate every increasing ruler with the fixed prefix, keep the
    // lexicographically first NR among those of minimum length.
    task automatic model(input logic [RW-1:0] start, input int first_var, input int maxv,
                         output int num, output logic [RESW-1:0] bus);
        int            pre [0:N];
        int            m   [0:N];
        int            lens[$];
        logic [RW-1:0] rulers[$];
        bit            seen[0:511];
        bit            ok;
        int            best;
        for (int i = 0; i <= N; i++) pre[i] = int'(start[(N-i)*MW +: MW]);
        for (int v1 = (first_var > 1) ? pre[1] : pre[0] + 1; v1 <= ((first_var > 1) ? pre[1] : maxv); v1++)
        for (int v2 = (first_var > 2) ? pre[2] : v1 + 1;     v2 <= ((first_var > 2) ? pre[2] : maxv); v2++)
        for (int v3 = (first_var > 3) ? pre[3] : v2 + 1;     v3 <= ((first_var > 3) ? pre[3] : maxv); v3++)
        for (int v4 = (first_var > 4) ? pre[4] : v3 + 1;     v4 <= ((first_var > 4) ? pre[4] : maxv); v4++)
        for (int v5 = (first_var > 5) ? pre[5] : v4 + 1;     v5 <= ((first_var > 5) ? pre[5] : maxv); v5++) begin
            m[0] = pre[0]; m[1] = v1; m[2] = v2; m[3] = v3; m[4] = v4; m[5] = v5;
            ok = (v5 <= maxv);
            for (int d = 0; d < 512; d++) seen[d] = 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = i + 1; j <= N; j++) begin
                    if (m[j] <= m[i]) ok = 1'b0;
                    else if (seen[m[j] - m[i]]) ok = 1'b0;
                    else seen[m[j] - m[i]] = 1'b1;
                end
            end
            if (ok) begin
                lens.push_back(v5);
                rulers.push_back(pk(m[0], v1, v2, v3, v4, v5));
            end
        end
        best = 1 << 20;
        foreach (lens[q]) if (lens[q] < best) best = lens[q];
        num = 0;
        bus = '0;
        foreach (lens[q]) begin
            if (lens[q] == best && num < NR) begin
                bus[(NR-1-num)*RW +: RW] = rulers[q];
                num++;
            end
        end
    endtask

    initial begin
        vec_t            vecs[4];
        logic [RESW-1:0] exp_bus;
        logic [RESW-1:0] default_bus;
        int              cycles;
        int              mnum;
        int              a;
        int              b;

        vecs[0] = '{maxv: 5'd30, fvp: 7'd2, start: pk(0,1,2,3,4,5), num: 6'd4,
                    exp: {pk(0,1,4,10,12,17), pk(0,1,4,10,15,17), pk(0,1,8,11,13,17),
                          pk(0,1,8,12,14,17), {(4*RW){1'b0}}}, cyc: 16'd0};
        vecs[1] = '{maxv: 5'd16, fvp: 7'd2, start: pk(0,1,2,3,4,5), num: 6'd0,
                    exp: '0, cyc: 16'd0};
        vecs[2] = '{maxv: 5'd17, fvp: 7'd1, start: pk(0,1,2,3,4,5), num: 6'd8,
                    exp: {pk(0,1,4,10,12,17), pk(0,1,4,10,15,17), pk(0,1,8,11,13,17),
                          pk(0,1,8,12,14,17), pk(0,2,7,13,16,17), pk(0,3,5,9,16,17),
                          pk(0,4,6,9,16,17), pk(0,5,7,13,16,17)}, cyc: 16'd0};
        vecs[3] = '{maxv: 5'd30, fvp: 7'd7, start: pk(0,1,4,10,12,17), num: 6'd1,
                    exp: {pk(0,1,4,10,12,17), {(7*RW){1'b0}}}, cyc: 16'd1};
        default_bus = {vecs[0].exp, {((NR-8)*RW){1'b0}}};

        reset = 1'b0;
        sel   = 30;
        fvp   = 7'd2;
        fv    = pk(0,1,2,3,4,5);

        // Reset state, sampled while reset is still held.
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_marks",   sel_marks,   pk(0,1,2,3,4,5));
        check("reset_num",     sel_num,     0);
        check("reset_done",    sel_done,    0);
        check("reset_results", sel_results, 0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            sel = int'(vecs[i].maxv);
            fvp = vecs[i].fvp;
            fv  = vecs[i].start;
            apply_reset(1);
            run_search(40000, cycles);
            exp_bus = {vecs[i].exp, {((NR-8)*RW){1'b0}}};
            check($sformatf("row%0d_num", i),     sel_num,     vecs[i].num);
            check($sformatf("row%0d_results", i), sel_results, exp_bus);
            if (vecs[i].cyc != 0) begin
                check($sformatf("row%0d_cycles", i), cycles, vecs[i].cyc);
                repeat (5) @(negedge clock);
                check($sformatf("row%0d_hold_marks", i),   sel_marks,   vecs[i].start);
                check($sformatf("row%0d_hold_done", i),    sel_done,    1);
                check($sformatf("row%0d_hold_results", i), sel_results, exp_bus);
            end
        end

        // Reset in the middle of the default search, then rerun to completion.
        sel = 30;
        fvp = 7'd2;
        fv  = pk(0,1,2,3,4,5);
        apply_reset(1);
        repeat (1000) @(negedge clock);
        check("mid_not_done", sel_done, 0);
        reset = 1'b1;
        @(negedge clock);
        check("mid_reset_marks",   sel_marks,   pk(0,1,2,3,4,5));
        check("mid_reset_num",     sel_num,     0);
        check("mid_reset_done",    sel_done,    0);
        check("mid_reset_results", sel_results, 0);
        reset = 1'b0;
        run_search(40000, cycles);
        check("rerun_num",     sel_num,     4);
        check("rerun_results", sel_results, default_bus);

        // Random fixed prefixes 0,a,b against the reference enumeration.
        for (int t = 0; t < 4; t++) begin
            a   = int'($urandom_range(1, 4));
            b   = a + int'($urandom_range(1, 6));
            sel = 30;
            fvp = 7'd3;
            fv  = pk(0, a, b, b + 1, b + 2, b + 3);
            apply_reset(1);
            run_search(40000, cycles);
            model(fv, 3, 30, mnum, exp_bus);
            check($sformatf("rand%0d_num_0_%0d_%0d", t, a, b),     sel_num,     mnum);
            check($sformatf("rand%0d_results_0_%0d_%0d", t, a, b), sel_results, exp_bus);
            check($sformatf("rand%0d_done_0_%0d_%0d", t, a, b),    sel_done,    1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
